fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Consumer of the 2-bit PCSel redirect code produced in ID.
- Owns the PC register and drives the address port of the synchronous-read instruction memory (1-cycle read latency).
- Pairs each returned instruction with its PC and registers it into ID.
- Squashes the wrong-path slot on a redirect and holds everything on stall.

Parameters:
- RESET_PC, 32'h4000_0000, first fetch address after reset (BIOS base).
- NOP_INSTR, 32'h0000_0013, encoding injected into ID on squash/reset (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- stall  input  1  hazard stall from ID; freezes PC and ID register.
- PCSel  input  2  00 sequential, 01 JAL target, 10 branch/JALR target, 11 reserved (treated as 00).
- jal_target  input  32  JAL target computed in ID.
- alu_target  input  32  branch/JALR target from ALU.
- imem_addr  output  32  combinational address presented to instruction memory this cycle.
- instr_in  input  32  memory read data for the address presented last cycle.
- pc_if  output  32  registered PC whose instruction is on instr_in this cycle.
- pc_id  output  32  PC of instruction in ID.
- instr_id  output  32  instruction in ID.
- valid_id  output  1  1 = instr_id is a real fetched instruction; 0 = bubble.

Behaviour:
- Reset (rst_n=0 at edge):
  - pc_if <= RESET_PC; pc_id <= 0; instr_id <= NOP_INSTR; valid_id <= 0.
  - imem_addr = RESET_PC combinationally while rst_n=0, so the first word is ready on the first cycle after reset.
- Next-PC select (combinational, drives imem_addr), priority top down:
  1. rst_n=0 -> RESET_PC.
  2. stall=1 -> pc_if (re-read same word; PCSel ignored).
  3. PCSel=01 -> jal_target.
  4. PCSel=10 -> alu_target.
  5. Otherwise (00 or 11) -> pc_if + 4.
- Targets: bits [1:0] forced to 0 before use. PC arithmetic is modulo 2^32; pc_if=32'hFFFF_FFFC sequential -> 32'h0000_0000, no flag.
- Every non-reset edge: pc_if <= imem_addr.
- ID register update, non-reset edge:
  - stall=1: pc_id, instr_id, valid_id hold.
  - redirect (PCSel=01 or 10, stall=0): the word on instr_in is wrong-path. instr_id <= NOP_INSTR, valid_id <= 0, pc_id <= pc_if (debug only).
  - Otherwise: instr_id <= instr_in, pc_id <= pc_if, valid_id <= 1.
- Redirect penalty: exactly one bubble in ID. Target instruction reaches ID on the second edge after the redirect cycle.
- Back-to-back redirects: PCSel is only meaningful when valid_id=1. The unit does not gate PCSel on valid_id; the ID-stage decode must drive 00 for bubbles.
- Stall held N cycles: imem_addr stays pc_if for N cycles. On release, the instruction in ID proceeds and fetch resumes with no lost or duplicated instruction.
- Reset asserted mid-stream (including during stall or redirect): reset wins. State returns to reset values on that edge; any in-flight redirect is discarded.
- Latency: address to ID is 2 edges (address edge, then ID capture edge).

Test Plan:
- Reset release: rst_n low 3 cycles, then high, PCSel=00, memory returns addr-as-data.
  - During reset: imem_addr=4000_0000.
  - Edge 1: instr_id=4000_0000, valid_id=1.
  - Then pc_id steps 4000_0004, 4000_0008.
- JAL redirect: at pc_if=4000_0010 drive PCSel=01, jal_target=4000_0103.
  - That cycle: imem_addr=4000_0100.
  - Next edge: instr_id=0000_0013, valid_id=0.
  - Following edge: pc_id=4000_0100, valid_id=1.
- Branch taken: PCSel=10, alu_target=1000_0020 -> one bubble, then pc_id=1000_0020, then 1000_0024.
- Stall: stall=1 for 3 cycles at pc_if=4000_0008.
  - imem_addr=4000_0008 throughout; pc_id/instr_id unchanged.
  - PCSel=10 during the stall is ignored.
  - After release the sequence continues 4000_0008, 4000_000C with no gap or duplicate.
- Wrap: force pc_if=FFFF_FFFC, PCSel=00 -> imem_addr=0000_0000; next edge pc_id=FFFF_FFFC.
- Reset during redirect: PCSel=10 and rst_n=0 on the same edge -> pc_if=4000_0000, valid_id=0, instr_id=0000_0013.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC unit: owns the PC, addresses a 1-cycle synchronous
// instruction memory and registers the returned word with its PC into ID.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h4000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  PCSel,
  input  logic [31:0] jal_target,
  input  logic [31:0] alu_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_if,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        valid_id
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SEL_JAL = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  logic            redirect;
  logic [XLEN-1:0] pc_seq;

  // A redirect only takes effect when the pipe is moving.
  assign redirect = !stall && ((PCSel == SEL_JAL) || (PCSel == SEL_ALU));
  assign pc_seq   = pc_if + XLEN'(4);

  // Next-PC select; targets are word-aligned by clearing bits [1:0].
  always_comb begin
    imem_addr = pc_seq;
    if (!rst_n) begin
      imem_addr = RESET_PC;
    end else if (stall) begin
      imem_addr = pc_if;
    end else if (PCSel == SEL_JAL) begin
      imem_addr = {jal_target[XLEN-1:2], 2'b00};
    end else if (PCSel == SEL_ALU) begin
      imem_addr = {alu_target[XLEN-1:2], 2'b00};
    end
  end

  // PC and IF/ID register; the word arriving during a redirect is wrong-path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_if    <= RESET_PC;
      pc_id    <= '0;
      instr_id <= NOP_INSTR;
      valid_id <= 1'b0;
    end else begin
      pc_if <= imem_addr;
      if (!stall) begin
        pc_id <= pc_if;
        if (redirect) begin
          instr_id <= NOP_INSTR;
          valid_id <= 1'b0;
        end else begin
          instr_id <= instr_in;
          valid_id <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; memory model returns the address as data.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  PCSel;
  logic [31:0] jal_target;
  logic [31:0] alu_target;
  logic [31:0] imem_addr;
  logic [31:0] instr_in;
  logic [31:0] pc_if;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        valid_id;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_pc_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .PCSel      (PCSel),
    .jal_target (jal_target),
    .alu_target (alu_target),
    .imem_addr  (imem_addr),
    .instr_in   (instr_in),
    .pc_if      (pc_if),
    .pc_id      (pc_id),
    .instr_id   (instr_id),
    .valid_id   (valid_id)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory, data = address.
  always @(posedge clk) instr_in <= imem_addr;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                        input logic v);
    chk({tag, ".pc_id"}, pc_id, pc);
    chk({tag, ".instr_id"}, instr_id, ins);
    chk({tag, ".valid_id"}, 32'(valid_id), 32'(v));
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; PCSel = 2'b00;
    jal_target = '0; alu_target = '0;
    #1;
    chk("rst_addr", imem_addr, 32'h4000_0000);
    repeat (3) tick();
    chk("rst_addr2", imem_addr, 32'h4000_0000);
    chk("rst_pc_if", pc_if, 32'h4000_0000);
    chk_id("rst", 32'h0, NOP, 1'b0);

    // Reset release, sequential fetch.
    rst_n = 1'b1; #1;
    chk("seq_addr", imem_addr, 32'h4000_0004);
    tick();
    chk_id("e1", 32'h4000_0000, 32'h4000_0000, 1'b1);
    tick();
    chk_id("e2", 32'h4000_0004, 32'h4000_0004, 1'b1);
    chk("e2_pc_if", pc_if, 32'h4000_0008);

    // Stall 3 cycles with a branch request that must be ignored.
    stall = 1'b1; PCSel = 2'b10; alu_target = 32'h1000_0020; #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", imem_addr, 32'h4000_0008);
      tick();
      chk_id("stall", 32'h4000_0004, 32'h4000_0004, 1'b1);
      chk("stall_pc_if", pc_if, 32'h4000_0008);
    end
    stall = 1'b0; PCSel = 2'b00; #1;
    tick();
    chk_id("rel1", 32'h4000_0008, 32'h4000_0008, 1'b1);
    tick();
    chk_id("rel2", 32'h4000_000C, 32'h4000_000C, 1'b1);
    chk("rel2_pc_if", pc_if, 32'h4000_0010);

    // JAL redirect with misaligned target.
    PCSel = 2'b01; jal_target = 32'h4000_0103; #1;
    chk("jal_addr", imem_addr, 32'h4000_0100);
    tick();
    chk_id("jal_bub", 32'h4000_0010, NOP, 1'b0);
    PCSel = 2'b00; #1;
    tick();
    chk_id("jal_tgt", 32'h4000_0100, 32'h4000_0100, 1'b1);

    // Branch taken.
    PCSel = 2'b10; alu_target = 32'h1000_0020; #1;
    chk("br_addr", imem_addr, 32'h1000_0020);
    tick();
    chk("br_bub_valid", 32'(valid_id), 32'h0);
    chk("br_bub_instr", instr_id, NOP);
    PCSel = 2'b00; #1;
    tick();
    chk_id("br_tgt", 32'h1000_0020, 32'h1000_0020, 1'b1);
    tick();
    chk_id("br_seq", 32'h1000_0024, 32'h1000_0024, 1'b1);

    // Reserved code 11 behaves as sequential.
    PCSel = 2'b11; #1;
    chk("sel11_addr", imem_addr, 32'h1000_002C);
    tick();
    chk_id("sel11", 32'h1000_0028, 32'h1000_0028, 1'b1);

    // Wrap from FFFF_FFFC to 0.
    PCSel = 2'b01; jal_target = 32'hFFFF_FFFF; #1;
    chk("wrap_jal_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    PCSel = 2'b00; #1;
    chk("wrap_pc_if", pc_if, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    tick();
    chk_id("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
    chk("wrap_pc_if2", pc_if, 32'h0000_0000);

    // Reset on the same edge as a redirect.
    PCSel = 2'b10; alu_target = 32'h1234_5678; rst_n = 1'b0; #1;
    chk("rr_addr", imem_addr, 32'h4000_0000);
    tick();
    chk("rr_pc_if", pc_if, 32'h4000_0000);
    chk_id("rr", 32'h0, NOP, 1'b0);
    rst_n = 1'b1; PCSel = 2'b00; #1;
    tick();
    chk_id("rr_rel", 32'h4000_0000, 32'h4000_0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
